// File: rtl/ddr3_test_master_if.sv
// sysIO user-port bundle between the test master and the slowDDR3 controller.
// master = traffic initiator, slave = controller (or bench stub).
interface ddr3_test_master_if;
    logic        init_fin;
    logic [26:0] address;
    logic [1:0]  sel;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_payload;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_payload;

    modport master (
        input  init_fin,
        output address,
        output sel,
        output wr_valid,
        input  wr_ready,
        output wr_payload,
        output rd_ready,
        input  rd_valid,
        input  rd_payload
    );

    modport slave (
        output init_fin,
        input  address,
        input  sel,
        input  wr_valid,
        output wr_ready,
        input  wr_payload,
        input  rd_ready,
        output rd_valid,
        output rd_payload
    );
endinterface

// File: rtl/ddr3_test_master.sv
// Write/readback pattern tester for the slowDDR3 sysIO port.
// Ports: clk, resetn (sync, active low), start, sysio (master), busy/done/pass/timeout, error stats.
module ddr3_test_master #(
    parameter int unsigned WORDS   = 66560,
    parameter logic [15:0] SEED    = 16'h0000,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    ddr3_test_master_if.master   sysio,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [15:0]          err_cnt,
    output logic [26:0]          first_err_addr,
    output logic [15:0]          first_err_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [27:0] LAST    = 28'(WORDS - 1);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
    localparam logic        WD_ON   = (TIMEOUT != 0);

    state_t      state, state_n;
    logic [27:0] cnt, cnt_n;
    logic [31:0] wdog, wdog_n;
    logic [15:0] err_n;
    logic [26:0] fea_n;
    logic [15:0] fed_n;
    logic        to_n;

    logic        wr_beat;
    logic        rd_beat;
    logic        wd_exp;
    logic [15:0] expect_data;

    assign expect_data = cnt[15:0] ^ SEED;
    assign wr_beat     = sysio.wr_valid & sysio.wr_ready;
    assign rd_beat     = sysio.rd_ready & sysio.rd_valid;
    assign wd_exp      = WD_ON && (wdog == WD_LAST);

    // Handshake outputs decode straight from registered state/cnt,
    // so address and payload hold until the beat moves cnt.
    assign sysio.sel        = 2'b00;
    assign sysio.wr_valid   = (state == S_WRITE);
    assign sysio.rd_ready   = (state == S_READ);
    assign sysio.address    = (state == S_WRITE || state == S_READ) ?
                              cnt[26:0] : 27'd0;
    assign sysio.wr_payload = (state == S_WRITE) ? expect_data : 16'd0;

    assign busy = (state == S_WAIT_INIT) || (state == S_WRITE) ||
                  (state == S_READ);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == 16'd0) && !timeout;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            cnt            <= '0;
            wdog           <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            wdog           <= wdog_n;
            err_cnt        <= err_n;
            first_err_addr <= fea_n;
            first_err_data <= fed_n;
            timeout        <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wdog_n  = wdog;
        err_n   = err_cnt;
        fea_n   = first_err_addr;
        fed_n   = first_err_data;
        to_n    = timeout;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_WAIT_INIT;
                    cnt_n   = '0;
                    wdog_n  = '0;
                    err_n   = '0;
                    fea_n   = '0;
                    fed_n   = '0;
                    to_n    = 1'b0;
                end
            end
            S_WAIT_INIT: begin
                if (sysio.init_fin) begin
                    state_n = S_WRITE;
                    wdog_n  = '0;
                end
            end
            S_WRITE: begin
                // A beat always wins over a simultaneous watchdog expiry.
                if (wr_beat) begin
                    wdog_n = '0;
                    if (cnt == LAST) begin
                        state_n = S_READ;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 28'd1;
                    end
                end else if (wd_exp) begin
                    to_n    = 1'b1;
                    state_n = S_DONE;
                    wdog_n  = '0;
                end else begin
                    wdog_n = wdog + 32'd1;
                end
            end
            S_READ: begin
                if (rd_beat) begin
                    wdog_n = '0;
                    cnt_n  = cnt + 28'd1;
                    if (sysio.rd_payload != expect_data) begin
                        if (err_cnt != 16'hFFFF)
                            err_n = err_cnt + 16'd1;
                        if (err_cnt == 16'd0) begin
                            fea_n = cnt[26:0];
                            fed_n = sysio.rd_payload;
                        end
                    end
                    if (cnt == LAST)
                        state_n = S_DONE;
                end else if (wd_exp) begin
                    to_n    = 1'b1;
                    state_n = S_DONE;
                    wdog_n  = '0;
                end else begin
                    wdog_n = wdog + 32'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr3_test_master.sv
// Scoreboard bench for ddr3_test_master with a stub sysIO controller.
// Stimulus queues expected beats/status; a negedge monitor pops and compares.
module tb_ddr3_test_master;

    localparam int          WORDS = 16;
    localparam logic [15:0] SEED  = 16'h5A00;
    localparam int          TO    = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;
    logic [26:0] first_err_addr;
    logic [15:0] first_err_data;

    always #5 clk = ~clk;

    ddr3_test_master_if sio();

    ddr3_test_master #(
        .WORDS(WORDS),
        .SEED(SEED),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .sysio(sio),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timeout(timeout),
        .err_cnt(err_cnt),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    typedef struct packed {
        logic [26:0] a;
        logic [15:0] d;
    } beat_t;

    typedef struct packed {
        logic [15:0] e;
        logic [26:0] a;
        logic [15:0] d;
        logic        p;
        logic        t;
    } stat_t;

    beat_t       wr_q[$];
    logic [26:0] rd_q[$];
    stat_t       st_q[$];

    int          checks = 0;
    int          fails = 0;
    logic [15:0] mem[32];
    bit          corrupt[32];
    int          stall_after = -1;
    int          wbeats = 0;
    bit          rnd = 1'b0;
    int          wst = 0;
    int          rst_cnt = 0;
    int          cyc = 0;
    int          beat_cyc = 0;
    int          done_cyc = 0;
    logic        done_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(string name);
        checks++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Stub controller: drives ready/valid and read data after each edge.
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 16'hDEAD;
            corrupt[i] = 1'b0;
        end
        sio.wr_ready = 1'b0;
        sio.rd_valid = 1'b0;
        sio.rd_payload = 16'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd) begin
                sio.wr_ready = ($urandom_range(0, 1) == 1) || (wst >= 3);
                sio.rd_valid = ($urandom_range(0, 1) == 1) || (rst_cnt >= 3);
                wst = sio.wr_ready ? 0 : wst + 1;
                rst_cnt = sio.rd_valid ? 0 : rst_cnt + 1;
            end else begin
                sio.wr_ready = (stall_after < 0) || (wbeats < stall_after);
                sio.rd_valid = 1'b1;
            end
            sio.rd_payload = corrupt[sio.address[4:0]] ?
                             16'h0000 : mem[sio.address[4:0]];
        end
    end

    // Monitor: beats are decided by now, they land on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sio.wr_valid && sio.wr_ready) begin
                mem[sio.address[4:0]] = sio.wr_payload;
                wbeats++;
                if (wbeats == stall_after)
                    beat_cyc = cyc;
                if (wr_q.size() == 0) begin
                    flag_fail("unexpected write beat");
                end else begin
                    beat_t b;
                    b = wr_q.pop_front();
                    check("wr_addr", 64'(sio.address), 64'(b.a));
                    check("wr_data", 64'(sio.wr_payload), 64'(b.d));
                end
            end
            if (sio.rd_ready && sio.rd_valid) begin
                if (rd_q.size() == 0) begin
                    flag_fail("unexpected read beat");
                end else begin
                    logic [26:0] a;
                    a = rd_q.pop_front();
                    check("rd_addr", 64'(sio.address), 64'(a));
                end
            end
            if (done && !done_d) begin
                done_cyc = cyc;
                if (st_q.size() == 0) begin
                    flag_fail("unexpected done");
                end else begin
                    stat_t s;
                    s = st_q.pop_front();
                    check("err_cnt", 64'(err_cnt), 64'(s.e));
                    check("first_err_addr", 64'(first_err_addr), 64'(s.a));
                    check("first_err_data", 64'(first_err_data), 64'(s.d));
                    check("pass", 64'(pass), 64'(s.p));
                    check("timeout", 64'(timeout), 64'(s.t));
                end
            end
            done_d = done;
        end
    end

    task automatic push_run(int nw, int nr, stat_t s);
        for (int i = 0; i < nw; i++)
            wr_q.push_back({27'(i), 16'(i) ^ SEED});
        for (int i = 0; i < nr; i++)
            rd_q.push_back(27'(i));
        st_q.push_back(s);
        wbeats = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done)
            flag_fail("done wait timed out");
        @(negedge clk);
    endtask

    task automatic check_zero(string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " pass"}, 64'(pass), 64'd0);
        check({tag, " timeout"}, 64'(timeout), 64'd0);
        check({tag, " err_cnt"}, 64'(err_cnt), 64'd0);
        check({tag, " fea"}, 64'(first_err_addr), 64'd0);
        check({tag, " fed"}, 64'(first_err_data), 64'd0);
        check({tag, " address"}, 64'(sio.address), 64'd0);
        check({tag, " payload"}, 64'(sio.wr_payload), 64'd0);
        check({tag, " wr_valid"}, 64'(sio.wr_valid), 64'd0);
        check({tag, " rd_ready"}, 64'(sio.rd_ready), 64'd0);
        check({tag, " sel"}, 64'(sio.sel), 64'd0);
    endtask

    initial begin
        int n;
        bit hit;
        sio.init_fin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b1;

        // Clean run: 1 start + 1 init + 16 writes + 16 reads edges.
        push_run(WORDS, WORDS, '{e: 16'd0, a: 27'd0, d: 16'd0, p: 1'b1, t: 1'b0});
        pulse_start();
        wait_done(n);
        check("run latency", 64'(n + 1), 64'd34);

        // Two corrupted words, restart from DONE.
        corrupt[5] = 1'b1;
        corrupt[9] = 1'b1;
        push_run(WORDS, WORDS, '{e: 16'd2, a: 27'd5, d: 16'd0, p: 1'b0, t: 1'b0});
        pulse_start();
        wait_done(n);
        corrupt[5] = 1'b0;
        corrupt[9] = 1'b0;

        // Write stall after 3 beats trips the watchdog.
        stall_after = 3;
        push_run(3, 0, '{e: 16'd0, a: 27'd0, d: 16'd0, p: 1'b0, t: 1'b1});
        pulse_start();
        wait_done(n);
        check("to wr_valid", 64'(sio.wr_valid), 64'd0);
        check("to done", 64'(done), 64'd1);
        check("to stall edges", 64'(done_cyc - beat_cyc), 64'd9);
        stall_after = -1;
        push_run(WORDS, WORDS, '{e: 16'd0, a: 27'd0, d: 16'd0, p: 1'b1, t: 1'b0});
        pulse_start();
        check("restart timeout clr", 64'(timeout), 64'd0);
        check("restart busy", 64'(busy), 64'd1);
        wait_done(n);

        // Reset mid-READ at cnt 7, after an error was captured.
        corrupt[3] = 1'b1;
        push_run(WORDS, WORDS, '{e: 16'd1, a: 27'd3, d: 16'd0, p: 1'b0, t: 1'b0});
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = sio.rd_ready && (sio.address == 27'd7);
        end
        if (!hit)
            flag_fail("reach read cnt 7");
        check("pre-reset err_cnt", 64'(err_cnt), 64'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid reset");
        resetn = 1'b1;
        wr_q.delete();
        rd_q.delete();
        st_q.delete();
        corrupt[3] = 1'b0;

        // init_fin low holds WAIT_INIT with no handshakes.
        sio.init_fin = 1'b0;
        push_run(WORDS, WORDS, '{e: 16'd0, a: 27'd0, d: 16'd0, p: 1'b1, t: 1'b0});
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check("wait busy", 64'(busy), 64'd1);
        check("wait wr_valid", 64'(sio.wr_valid), 64'd0);
        check("wait rd_ready", 64'(sio.rd_ready), 64'd0);
        sio.init_fin = 1'b1;
        wait_done(n);

        // Random stub handshakes, start pulsed mid-WRITE is ignored.
        rnd = 1'b1;
        push_run(WORDS, WORDS, '{e: 16'd0, a: 27'd0, d: 16'd0, p: 1'b1, t: 1'b0});
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            hit = sio.wr_valid && (sio.address >= 27'd3);
        end
        if (!hit)
            flag_fail("reach write phase");
        pulse_start();
        wait_done(n);
        rnd = 1'b0;

        check("wr_q drained", 64'(wr_q.size()), 64'd0);
        check("rd_q drained", 64'(rd_q.size()), 64'd0);
        check("st_q drained", 64'(st_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
